fcmp_pipe: RTL
==============

Name: fcmp_pipe

Overview:
Two-stage pipelined single-precision compare and min/max unit for the FPU. It is the sequential, handshaked FPU-side responder that the core issue logic drives for feq/flt/fle/fmin/fmax. Operands arrive with a tag over a valid/ready interface. The result returns with the same tag over a valid/ready interface.

Parameters:
TAG_W, 5, width of the opaque tag carried alongside each operation (e.g. destination register index).

Ports:
clk  in  1  system clock; single clock domain.
rstn  in  1  reset, asynchronous, active-low.
in_valid  in  1  operation request valid.
in_ready  out  1  unit can accept a request this cycle.
in_op  in  3  operation code: 0 feq, 1 flt, 2 fle, 3 fmin, 4 fmax, 5-7 reserved.
in_x1  in  32  operand 1, IEEE-754 single.
in_x2  in  32  operand 2, IEEE-754 single.
in_tag  in  TAG_W  tag, returned unchanged.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_y  out  32  result: 0/1 zero-extended for compares; selected operand for min/max.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Ordering key per operand: if bits[30:0]==0, key=0x80000000, so +0 and -0 get one canonical key. Else if sign=0, key={1'b1,bits[30:0]}. Else key={1'b0,~bits[30:0]}. Keys are compared unsigned.
- NaN/denormal: no special handling. Operands are ordered by key only; this is a documented limitation.
- Stage 1 (S1): on accept, register both keys, both raw operands, op and tag; set s1_valid.
- Stage 2 (S2): compute eq=(k1==k2), lt=(k1<k2) from the S1 registers, select the result and register it into out_y/out_tag; set s2_valid.
- Ops:
  - feq -> eq.
  - flt -> lt.
  - fle -> lt|eq.
  - fmin -> (k2<k1) ? x2 : x1.
  - fmax -> (k1<k2) ? x2 : x1.
  - Ties in fmin/fmax return x1 raw bits, so fmin(-0,+0)=0x80000000.
  - Reserved ops -> 0x00000000.
- Latency: 2 cycles from accept (in_valid&in_ready at edge N) to out_valid at edge N+2, when there is no backpressure.
- Handshake:
  - Transfers occur on rising clk when valid&ready are both high.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1, combinational from out_ready and the valid flags. There is no combinational path from in_valid to in_ready.
  - out_valid = s2_valid.
  - While out_valid=1 and out_ready=0, out_y and out_tag are held stable and nothing is lost. Full throughput is one operation per cycle.
- Stage valid updates:
  - S2 loads when adv2: s2_valid <= s1_valid.
  - S1 loads when adv1: s1_valid <= in_valid.
- Full: both stages valid and out_ready=0 -> in_ready=0.
- Empty: in_ready=1 and out_valid=0.
- Simultaneous out-handshake and in-handshake in a full pipe: both complete in the same cycle, and occupancy is unchanged.
- Reset:
  - Asynchronous assert clears s1_valid, s2_valid, out_y=0, out_tag=0.
  - in_ready reads 1 once reset is deasserted.
  - In-flight operations are discarded on reset mid-operation.
  - Data registers other than the outputs need no reset.

Decomposition:
- Shared FPU package holds:
  - The opcode constants OP_FEQ=3'd0, OP_FLT=3'd1, OP_FLE=3'd2, OP_FMIN=3'd3, OP_FMAX=3'd4.
  - The canonical zero key 32'h80000000.
- One natural sub-module: fkey_enc, a combinational 32-bit float to ordering-key encoder, instantiated twice in S1.

Test Plan:
- Compares: fle(0x3F800000,0x40000000) -> out_y=1 two cycles after accept. flt(0xBF800000,0x3F800000) -> 1. flt(0x40000000,0x3F800000) -> 0. Tag 5'd7 is returned as 5'd7.
- Signed zeros: feq(0x80000000,0x00000000) -> 1. fle(0x00000000,0x80000000) -> 1. flt(0x80000000,0x00000000) -> 0. fmin(0x80000000,0x00000000) -> 0x80000000.
- Min/max negatives: fmax(0xBF800000,0xC0000000) -> 0xBF800000. fmin(0xBF800000,0xC0000000) -> 0xC0000000. Reserved op 3'd6 -> 0x00000000.
- Backpressure: issue 4 back-to-back ops with out_ready=0.
  - in_ready drops after 2 are accepted.
  - out_y is held stable while stalled.
  - Raising out_ready drains all 4 in order with the correct tags, none dropped or duplicated.
- Throughput: with out_ready=1 held high, issue 10 consecutive ops -> 10 results on 10 consecutive cycles starting 2 cycles after the first accept.
- Reset mid-operation: assert rstn=0 asynchronously with 2 ops in flight.
  - out_valid=0 and out_y=0 immediately, without waiting for a clock edge.
  - After release, in_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/fcmp_pipe_pkg.sv
// ---------------------------------------------------------------
// fcmp_pipe_pkg : opcodes and key constants for the FP compare unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package fcmp_pipe_pkg;

  typedef logic [31:0] key_t;

  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;

  // +0 and -0 both map here so they compare equal.
  localparam key_t KEY_ZERO = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/fcmp_pipe_if.sv
// ---------------------------------------------------------------
// fcmp_pipe_if : request/response valid-ready bundle of fcmp_pipe
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface fcmp_pipe_if #(
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag
  );

endinterface

`default_nettype wire

// File: rtl/fcmp_pipe_fkey_enc.sv
// ---------------------------------------------------------------
// fcmp_pipe_fkey_enc : float bits -> unsigned-comparable ordering key
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fcmp_pipe_fkey_enc
  import fcmp_pipe_pkg::*;
(
  input  logic [31:0] f_i,
  output key_t        key_o
);

  always_comb begin
    key_o = KEY_ZERO;
    if (f_i[30:0] != 31'd0) begin
      // Negative magnitudes are inverted so larger magnitude sorts lower.
      key_o = f_i[31] ? {1'b0, ~f_i[30:0]} : {1'b1, f_i[30:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fcmp_pipe.sv
// ---------------------------------------------------------------
// fcmp_pipe : two-stage pipelined FP compare and min/max unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fcmp_pipe
  import fcmp_pipe_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         rstn,
  fcmp_pipe_if.slave   bus
);

  logic             adv1;
  logic             adv2;
  logic             s1_valid_q;
  logic             s2_valid_q;
  key_t             k1_d;
  key_t             k2_d;
  key_t             k1_q;
  key_t             k2_q;
  logic [31:0]      x1_q;
  logic [31:0]      x2_q;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      y_d;
  logic [31:0]      y_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             eq;
  logic             lt;

  assign adv2         = !s2_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_y    = y_q;
  assign bus.out_tag  = out_tag_q;

  fcmp_pipe_fkey_enc u_fkey_enc_x1 (.f_i(bus.in_x1), .key_o(k1_d));
  fcmp_pipe_fkey_enc u_fkey_enc_x2 (.f_i(bus.in_x2), .key_o(k2_d));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      k1_q  <= k1_d;
      k2_q  <= k2_d;
      x1_q  <= bus.in_x1;
      x2_q  <= bus.in_x2;
      op_q  <= bus.in_op;
      tag_q <= bus.in_tag;
    end
  end

  always_comb begin
    eq  = (k1_q == k2_q);
    lt  = (k1_q < k2_q);
    y_d = 32'h0000_0000;
    case (op_q)
      OP_FEQ:  y_d = {31'd0, eq};
      OP_FLT:  y_d = {31'd0, lt};
      OP_FLE:  y_d = {31'd0, lt | eq};
      // Ties fall through to x1, which fixes fmin(-0,+0) = -0.
      OP_FMIN: y_d = (k2_q < k1_q) ? x2_q : x1_q;
      OP_FMAX: y_d = lt ? x2_q : x1_q;
      default: y_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
      y_q        <= 32'h0000_0000;
      out_tag_q  <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y_q       <= y_d;
        out_tag_q <= tag_q;
      end
    end
  end

endmodule

`default_nettype wire
